// File: rtl/usb_fs_tx_serializer.sv
// rtl/usb_fs_tx_serializer.sv - full-speed USB transmit serializer (sync, NRZI, bit stuffing, CRC16, EOP)
module usb_fs_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_crc16,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  // S_TAIL is an empty payload segment so a trailing stuff bit can precede EOP.
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_CRC_HI, S_CRC_LO, S_TAIL, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    left_q, left_d;
  logic [2:0]    stuff_q, stuff_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    byte_q, byte_d;
  logic          line_q, line_d;
  logic          last_q, last_d;
  logic          crc_en_q, crc_en_d;
  logic          pid_q, pid_d;
  logic          p_q, p_d;
  logic          n_q, n_d;
  logic          en_q, en_d;

  state_t        seg_state;
  logic [7:0]    seg_shift;
  logic [3:0]    seg_left;
  logic          seg_pid;
  logic          bit_end;
  logic [15:0]   crc_rev;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign usb_p_tx  = p_q;
  assign usb_n_tx  = n_q;
  assign usb_tx_en = en_q;
  assign tx_busy   = (state_q != S_IDLE);

  // crc_rev[0] is the first CRC bit on the wire: complemented register bit 15.
  always_comb begin
    crc_rev = '0;
    for (int i = 0; i < 16; i++) begin
      crc_rev[i] = ~crc_q[15-i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    stuff_d     = stuff_q;
    crc_d       = crc_q;
    byte_d      = byte_q;
    line_d      = line_q;
    last_d      = last_q;
    crc_en_d    = crc_en_q;
    pid_d       = pid_q;
    p_d         = p_q;
    n_d         = n_q;
    en_d        = en_q;
    tx_ready    = 1'b0;
    tx_underrun = 1'b0;
    seg_state   = state_q;
    seg_shift   = shift_q;
    seg_left    = left_q;
    seg_pid     = pid_q;

    case (state_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        cnt_d    = '0;
        if (tx_valid) begin
          state_d  = S_SYNC;
          byte_d   = tx_data;
          last_d   = tx_last;
          crc_en_d = tx_crc16;
          pid_d    = 1'b1;
          crc_d    = 16'hFFFF;
          shift_d  = 8'h40;
          left_d   = 4'd7;
          stuff_d  = 3'd0;
          line_d   = 1'b0;
          p_d      = 1'b0;
          n_d      = 1'b1;
          en_d     = 1'b1;
        end
      end

      S_SYNC, S_DATA, S_CRC_HI, S_CRC_LO, S_TAIL: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          if (left_q == 4'd0) begin
            case (state_q)
              S_SYNC: begin
                seg_state = S_DATA;
                seg_shift = byte_q;
                seg_left  = 4'd8;
              end
              S_DATA: begin
                if (last_q) begin
                  seg_state = crc_en_q ? S_CRC_HI : S_TAIL;
                  seg_shift = crc_rev[7:0];
                  seg_left  = crc_en_q ? 4'd8 : 4'd0;
                end else begin
                  tx_ready = 1'b1;
                  if (tx_valid) begin
                    seg_shift = tx_data;
                    seg_left  = 4'd8;
                    seg_pid   = 1'b0;
                    last_d    = tx_last;
                  end else begin
                    tx_underrun = 1'b1;
                    seg_state   = S_TAIL;
                    seg_left    = 4'd0;
                  end
                end
              end
              S_CRC_HI: begin
                seg_state = S_CRC_LO;
                seg_shift = crc_rev[15:8];
                seg_left  = 4'd8;
              end
              default: begin
                seg_state = S_TAIL;
                seg_left  = 4'd0;
              end
            endcase
          end

          state_d = seg_state;
          shift_d = seg_shift;
          left_d  = seg_left;
          pid_d   = seg_pid;

          if (stuff_q == 3'd6) begin
            line_d  = ~line_q;
            stuff_d = 3'd0;
          end else if (seg_left != 4'd0) begin
            shift_d = seg_shift >> 1;
            left_d  = seg_left - 4'd1;
            if (seg_shift[0]) begin
              stuff_d = stuff_q + 3'd1;
            end else begin
              stuff_d = 3'd0;
              line_d  = ~line_q;
            end
            if (seg_state == S_DATA && !seg_pid) begin
              crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ seg_shift[0]) ? 16'h8005 : 16'h0000);
            end
          end else begin
            state_d = S_EOP_SE0;
            left_d  = 4'd1;
          end

          if (state_d == S_EOP_SE0) begin
            p_d = 1'b0;
            n_d = 1'b0;
          end else begin
            p_d = line_d;
            n_d = ~line_d;
          end
        end
      end

      S_EOP_SE0: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          if (left_q != 4'd0) begin
            left_d = left_q - 4'd1;
          end else begin
            state_d = S_EOP_J;
            line_d  = 1'b1;
            p_d     = 1'b1;
            n_d     = 1'b0;
          end
        end
      end

      S_EOP_J: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      left_q   <= '0;
      stuff_q  <= '0;
      crc_q    <= '0;
      byte_q   <= '0;
      line_q   <= 1'b1;
      last_q   <= 1'b0;
      crc_en_q <= 1'b0;
      pid_q    <= 1'b0;
      p_q      <= 1'b1;
      n_q      <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      left_q   <= left_d;
      stuff_q  <= stuff_d;
      crc_q    <= crc_d;
      byte_q   <= byte_d;
      line_q   <= line_d;
      last_q   <= last_d;
      crc_en_q <= crc_en_d;
      pid_q    <= pid_d;
      p_q      <= p_d;
      n_q      <= n_d;
      en_q     <= en_d;
    end
  end

endmodule
